test_vector_sequencer: RTL and testbench

// - Parametrised, self-checking stimulus player for ALU_System and Control_Unit benches.
// - Holds DEPTH vectors. Each vector carries stimulus, expected response and compare mask.
// - Plays the vectors on Clock, compares the masked DUT response, counts mismatches and reports done/pass.
// - Instantiated inside benches in place of ad-hoc $readmemb/always-block drivers.

---
 rtl/test_vector_sequencer.sv | 149 ++++++++++++++
 tb/tb_test_vector_sequencer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/test_vector_sequencer.sv
// Vector player: applies stored stimulus, checks the masked DUT response and counts mismatches.
// Optional STOP_ON_ERROR_EN: end the run at the first failing compare.
module test_vector_sequencer #(
    parameter int unsigned STIM_W    = 42,
    parameter int unsigned EXP_W     = 8,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned IDX_W     = $clog2(DEPTH),
    parameter              INIT_FILE = "TestBench.mem"
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic                          Start,
    input  logic                          Pause,
    input  logic                          Load_En,
    input  logic [IDX_W-1:0]              Load_Addr,
    input  logic [1+STIM_W+2*EXP_W-1:0]   Load_Data,
    input  logic [EXP_W-1:0]              Observed,
    output logic [STIM_W-1:0]             Stim,
    output logic                          Stim_Valid,
    output logic [IDX_W-1:0]              VectorNum,
    output logic [15:0]                   Errors,
    output logic                          Mismatch,
    output logic                          Busy,
    output logic                          Done,
    output logic                          Pass
);

    localparam int unsigned ENT_W    = 1 + STIM_W + 2*EXP_W;
    localparam int unsigned LAST_B   = ENT_W - 1;
    localparam int unsigned STIM_LSB = 2*EXP_W;
    localparam int unsigned EXP_LSB  = EXP_W;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_APPLY = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

`ifdef STOP_ON_ERROR_EN
    localparam bit STOP_ON_ERR = 1'b1;
`else
    localparam bit STOP_ON_ERR = 1'b0;
`endif

    logic [ENT_W-1:0]  mem_q [DEPTH];

    logic [1:0]        state_q, state_d;
    logic [STIM_W-1:0] stim_q,  stim_d;
    logic [IDX_W-1:0]  vec_q,   vec_d;
    logic [15:0]       err_q,   err_d;
    logic              mism_q,  mism_d;

    logic              idle_like;
    logic              load_ok;
    logic [IDX_W-1:0]  vec_nx;
    logic              cur_last;
    logic [EXP_W-1:0]  cur_exp;
    logic [EXP_W-1:0]  cur_mask;
    logic              miss;
    logic              end_of_list;
    logic [STIM_W-1:0] first_stim;
    logic [STIM_W-1:0] next_stim;

    assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE);
    assign load_ok   = Load_En && idle_like;

    // Memory is deliberately outside the reset domain so a mid-run reset keeps the vectors.
    always_ff @(posedge Clock) begin
        if (load_ok) begin
            mem_q[Load_Addr] <= Load_Data;
        end
    end

    assign vec_nx      = vec_q + IDX_W'(1);
    assign cur_last    = mem_q[vec_q][LAST_B];
    assign cur_exp     = mem_q[vec_q][EXP_LSB +: EXP_W];
    assign cur_mask    = mem_q[vec_q][0 +: EXP_W];
    assign next_stim   = mem_q[vec_nx][STIM_LSB +: STIM_W];
    assign miss        = ((Observed ^ cur_exp) & cur_mask) != '0;
    assign end_of_list = cur_last || (vec_q == IDX_W'(DEPTH - 1));

    // A write to entry 0 in the start cycle bypasses the memory so the run sees the new data.
    assign first_stim = (load_ok && (Load_Addr == '0)) ? Load_Data[STIM_LSB +: STIM_W]
                                                        : mem_q[0][STIM_LSB +: STIM_W];

    always_comb begin
        state_d = state_q;
        stim_d  = stim_q;
        vec_d   = vec_q;
        err_d   = err_q;
        mism_d  = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (Start) begin
                    state_d = S_APPLY;
                    vec_d   = '0;
                    err_d   = '0;
                    stim_d  = first_stim;
                end
            end
            S_APPLY: begin
                if (!Pause) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (!Pause) begin
                    mism_d = miss;
                    if (miss && (err_q != '1)) begin
                        err_d = err_q + 16'd1;
                    end
                    if (end_of_list || (STOP_ON_ERR && miss)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_APPLY;
                        vec_d   = vec_nx;
                        stim_d  = next_stim;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= S_IDLE;
            stim_q  <= '0;
            vec_q   <= '0;
            err_q   <= '0;
            mism_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stim_q  <= stim_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
            mism_q  <= mism_d;
        end
    end

    assign Stim       = stim_q;
    assign VectorNum  = vec_q;
    assign Errors     = err_q;
    assign Mismatch   = mism_q;
    assign Busy       = (state_q == S_APPLY) || (state_q == S_CHECK);
    assign Stim_Valid = Busy;
    assign Done       = (state_q == S_DONE);
    assign Pass       = Done && (err_q == '0);

endmodule

// File: tb/tb_test_vector_sequencer.sv
// Randomised bench for test_vector_sequencer against a vector-list reference model.
// Expectations follow STOP_ON_ERROR_EN when the macro is defined for the build.
module tb_test_vector_sequencer;

    localparam int STIM_W = 42;
    localparam int EXP_W  = 8;
    localparam int DEPTH  = 16;
    localparam int IDX_W  = 4;
    localparam int ENT_W  = 1 + STIM_W + 2*EXP_W;
    localparam int LIMIT  = 400;

`ifdef STOP_ON_ERROR_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic                Clock, Reset, Start, Pause, Load_En;
    logic [IDX_W-1:0]    Load_Addr;
    logic [ENT_W-1:0]    Load_Data;
    logic [EXP_W-1:0]    Observed;
    logic [STIM_W-1:0]   Stim;
    logic                Stim_Valid, Mismatch, Busy, Done, Pass;
    logic [IDX_W-1:0]    VectorNum;
    logic [15:0]         Errors;

    test_vector_sequencer #(
        .STIM_W(STIM_W), .EXP_W(EXP_W), .DEPTH(DEPTH), .INIT_FILE("")
    ) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Pause(Pause),
        .Load_En(Load_En), .Load_Addr(Load_Addr), .Load_Data(Load_Data),
        .Observed(Observed), .Stim(Stim), .Stim_Valid(Stim_Valid),
        .VectorNum(VectorNum), .Errors(Errors), .Mismatch(Mismatch),
        .Busy(Busy), .Done(Done), .Pass(Pass)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;

    // Reference vector list and the DUT response the bench will present for each entry.
    bit                m_last [DEPTH];
    logic [STIM_W-1:0] m_stim [DEPTH];
    logic [EXP_W-1:0]  m_exp  [DEPTH];
    logic [EXP_W-1:0]  m_mask [DEPTH];
    logic [EXP_W-1:0]  m_obs  [DEPTH];

    // Observations collected by the run driver.
    int                r_cycles, r_pulses, r_unstable, r_pause_cnt;
    bit                r_timeout;
    bit                r_seen [DEPTH];
    logic [STIM_W-1:0] r_stim [DEPTH];

    function automatic void model_run(output int last_idx, output int n_err);
        bit bad;
        n_err    = 0;
        last_idx = DEPTH - 1;
        for (int k = 0; k < DEPTH; k++) begin
            bad = ((m_obs[k] ^ m_exp[k]) & m_mask[k]) != 0;
            if (bad) n_err++;
            if (m_last[k] || (STOP && bad)) begin
                last_idx = k;
                break;
            end
        end
    endfunction

    function automatic logic [STIM_W-1:0] rand_stim();
        return STIM_W'({$urandom(), $urandom()});
    endfunction

    task automatic load_entry(input int a);
        Load_En   = 1'b1;
        Load_Addr = IDX_W'(a);
        Load_Data = {m_last[a], m_stim[a], m_exp[a], m_mask[a]};
        @(negedge Clock);
        Load_En   = 1'b0;
    endtask

    task automatic load_all();
        for (int k = 0; k < DEPTH; k++) load_entry(k);
    endtask

    task automatic fill_clean(input int last_at);
        for (int k = 0; k < DEPTH; k++) begin
            m_last[k] = (k == last_at);
            m_stim[k] = rand_stim();
            m_exp[k]  = EXP_W'($urandom());
            m_mask[k] = EXP_W'($urandom());
            m_obs[k]  = m_exp[k];
        end
    endtask

    // Starts a run from IDLE/DONE and plays the responding DUT until Done or the cycle budget.
    task automatic run_vectors(input int pause_from, input int pause_len,
                               input bit rand_pause, input bit noise);
        int cyc;
        for (int k = 0; k < DEPTH; k++) r_seen[k] = 1'b0;
        r_pulses = 0; r_unstable = 0; r_pause_cnt = 0;
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        cyc = 0;
        while (cyc < LIMIT) begin
            if (Mismatch === 1'b1) r_pulses++;
            if (Done === 1'b1) break;
            if (Stim_Valid === 1'b1) begin
                if (!r_seen[VectorNum]) begin
                    r_seen[VectorNum] = 1'b1;
                    r_stim[VectorNum] = Stim;
                end else if (Stim !== r_stim[VectorNum]) begin
                    r_unstable++;
                end
            end
            Observed = m_obs[VectorNum];
            Pause = rand_pause ? ($urandom_range(0, 3) == 0)
                               : (cyc >= pause_from && cyc < pause_from + pause_len);
            if (Pause) r_pause_cnt++;
            if (noise) begin
                Start     = 1'($urandom_range(0, 1));
                Load_En   = 1'($urandom_range(0, 1));
                Load_Addr = IDX_W'($urandom());
                Load_Data = ENT_W'({$urandom(), $urandom()});
            end
            @(negedge Clock);
            cyc++;
        end
        r_cycles  = cyc;
        r_timeout = (Done !== 1'b1);
        Pause = 1'b0; Start = 1'b0; Load_En = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (2) @(negedge Clock);
        checks++; if (Stim !== '0) begin errors++; $display("FAIL reset_stim: got %h expected 0", Stim); end
        checks++; if (Errors !== 16'd0) begin errors++; $display("FAIL reset_errors: got %0d expected 0", Errors); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", Busy); end
        checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", Done); end
        checks++; if (Pass !== 1'b0) begin errors++; $display("FAIL reset_pass: got %b expected 0", Pass); end
        checks++; if ({Stim_Valid, Mismatch, VectorNum} !== '0) begin errors++; $display("FAIL reset_misc: got valid=%b mism=%b vec=%0d expected all 0", Stim_Valid, Mismatch, VectorNum); end
        Reset = 1'b0;
        @(negedge Clock);
    endtask

    task automatic test_clean_run();
        fill_clean(3);
        load_all();
        run_vectors(LIMIT, 0, 1'b0, 1'b0);
        checks++; if (r_timeout || r_cycles != 8) begin errors++; $display("FAIL clean_cycles: got %0d (timeout=%b) expected 8", r_cycles, r_timeout); end
        checks++; if (VectorNum !== 4'd3) begin errors++; $display("FAIL clean_vecnum: got %0d expected 3", VectorNum); end
        checks++; if (Errors !== 16'd0 || Pass !== 1'b1) begin errors++; $display("FAIL clean_pass: got errors=%0d pass=%b expected 0/1", Errors, Pass); end
        checks++; if (Busy !== 1'b0 || Stim_Valid !== 1'b0) begin errors++; $display("FAIL clean_idle_flags: got busy=%b valid=%b expected 0/0", Busy, Stim_Valid); end
        checks++; if (Stim !== m_stim[3]) begin errors++; $display("FAIL clean_stim_hold: got %h expected %h", Stim, m_stim[3]); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (!r_seen[k] || r_stim[k] !== m_stim[k]) begin errors++; $display("FAIL clean_stim%0d: got %h expected %h", k, r_stim[k], m_stim[k]); end
        end
        checks++; if (r_seen[4] || r_unstable != 0 || r_pulses != 0) begin errors++; $display("FAIL clean_extra: got beyond=%b unstable=%0d pulses=%0d expected 0/0/0", r_seen[4], r_unstable, r_pulses); end
    endtask

    task automatic test_masked();
        m_exp[1] = 8'hA5; m_mask[1] = 8'hF0; m_obs[1] = 8'hAF;
        load_entry(1);
        run_vectors(LIMIT, 0, 1'b0, 1'b0);
        checks++; if (Errors !== 16'd0 || r_pulses != 0 || Pass !== 1'b1) begin errors++; $display("FAIL masked_ok: got errors=%0d pulses=%0d pass=%b expected 0/0/1", Errors, r_pulses, Pass); end
        m_mask[1] = 8'hFF;
        load_entry(1);
        run_vectors(LIMIT, 0, 1'b0, 1'b0);
        checks++; if (Errors !== 16'd1) begin errors++; $display("FAIL masked_err: got %0d expected 1", Errors); end
        checks++; if (r_pulses != 1 || Pass !== 1'b0) begin errors++; $display("FAIL masked_pulse: got pulses=%0d pass=%b expected 1/0", r_pulses, Pass); end
        checks++; if (VectorNum !== IDX_W'(STOP ? 1 : 3) || Done !== 1'b1) begin errors++; $display("FAIL masked_vec: got vec=%0d done=%b expected %0d/1", VectorNum, Done, STOP ? 1 : 3); end
    endtask

    task automatic test_multi_mismatch();
        for (int k = 1; k < 4; k++) begin
            m_mask[k] = 8'hFF;
            m_obs[k]  = m_exp[k] ^ 8'h3C;
            load_entry(k);
        end
        run_vectors(LIMIT, 0, 1'b0, 1'b0);
        checks++; if (Errors !== 16'(STOP ? 1 : 3)) begin errors++; $display("FAIL multi_errors: got %0d expected %0d", Errors, STOP ? 1 : 3); end
        checks++; if (VectorNum !== IDX_W'(STOP ? 1 : 3) || Done !== 1'b1) begin errors++; $display("FAIL multi_vec: got vec=%0d done=%b expected %0d/1", VectorNum, Done, STOP ? 1 : 3); end
        checks++; if (r_pulses != (STOP ? 1 : 3) || r_cycles != (STOP ? 4 : 8)) begin errors++; $display("FAIL multi_timing: got pulses=%0d cycles=%0d expected %0d/%0d", r_pulses, r_cycles, STOP ? 1 : 3, STOP ? 4 : 8); end
    endtask

    task automatic test_load_start();
        logic [STIM_W-1:0] ns;
        int n;
        ns = rand_stim();
        Load_En = 1'b1; Load_Addr = '0; Start = 1'b1;
        Load_Data = {m_last[0], ns, m_exp[0], m_mask[0]};
        @(negedge Clock);
        Load_En = 1'b0; Start = 1'b0;
        m_stim[0] = ns;
        checks++; if (Stim !== ns || Busy !== 1'b1 || VectorNum !== '0) begin errors++; $display("FAIL load_start: got stim=%h busy=%b vec=%0d expected %h/1/0", Stim, Busy, VectorNum, ns); end
        n = 0;
        while (Done !== 1'b1 && n < LIMIT) begin
            Observed = m_obs[VectorNum];
            @(negedge Clock);
            n++;
        end
        checks++; if (Done !== 1'b1) begin errors++; $display("FAIL load_start_done: got done=%b after %0d cycles expected 1", Done, n); end
    endtask

    task automatic test_pause();
        for (int k = 0; k < DEPTH; k++) begin
            m_obs[k]  = m_exp[k];
            m_last[k] = (k == 3);
        end
        load_all();
        run_vectors(4, 5, 1'b0, 1'b0);
        checks++; if (r_timeout || r_cycles != 13) begin errors++; $display("FAIL pause_apply_cycles: got %0d expected 13", r_cycles); end
        checks++; if (r_unstable != 0 || r_stim[2] !== m_stim[2]) begin errors++; $display("FAIL pause_stim: got unstable=%0d stim=%h expected 0/%h", r_unstable, r_stim[2], m_stim[2]); end
        checks++; if (Errors !== 16'd0 || VectorNum !== 4'd3) begin errors++; $display("FAIL pause_result: got errors=%0d vec=%0d expected 0/3", Errors, VectorNum); end
        run_vectors(5, 3, 1'b0, 1'b0);
        checks++; if (r_timeout || r_cycles != 11) begin errors++; $display("FAIL pause_check_cycles: got %0d expected 11", r_cycles); end
    endtask

    task automatic test_reset_midrun();
        m_mask[0] = 8'hFF;
        load_entry(0);
        m_obs[0] = m_exp[0] ^ 8'hFF;
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            Observed = m_obs[VectorNum];
            @(negedge Clock);
        end
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        checks++; if (Busy !== 1'b0 || Done !== 1'b0 || Errors !== 16'd0) begin errors++; $display("FAIL midreset_state: got busy=%b done=%b errors=%0d expected 0/0/0", Busy, Done, Errors); end
        checks++; if (Stim !== '0 || VectorNum !== '0 || Stim_Valid !== 1'b0) begin errors++; $display("FAIL midreset_regs: got stim=%h vec=%0d valid=%b expected 0/0/0", Stim, VectorNum, Stim_Valid); end
        m_obs[0] = m_exp[0];
        run_vectors(LIMIT, 0, 1'b0, 1'b0);
        checks++; if (r_cycles != 8 || Errors !== 16'd0 || VectorNum !== 4'd3) begin errors++; $display("FAIL midreset_replay: got cycles=%0d errors=%0d vec=%0d expected 8/0/3", r_cycles, Errors, VectorNum); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (r_stim[k] !== m_stim[k]) begin errors++; $display("FAIL midreset_mem%0d: got %h expected %h", k, r_stim[k], m_stim[k]); end
        end
    endtask

    task automatic test_random();
        int exp_last, exp_err, bad_stim;
        for (int it = 0; it < 6; it++) begin
            for (int k = 0; k < DEPTH; k++) begin
                m_last[k] = (it != 0) && ($urandom_range(0, 4) == 0);
                m_stim[k] = rand_stim();
                m_exp[k]  = EXP_W'($urandom());
                m_mask[k] = ($urandom_range(0, 5) == 0) ? 8'h00 : EXP_W'($urandom());
                m_obs[k]  = ($urandom_range(0, 1) == 0) ? m_exp[k] : EXP_W'($urandom());
            end
            load_all();
            model_run(exp_last, exp_err);
            run_vectors(0, 0, 1'b1, 1'b1);
            checks++; if (r_timeout || VectorNum !== IDX_W'(exp_last)) begin errors++; $display("FAIL rand%0d_vec: got %0d (timeout=%b) expected %0d", it, VectorNum, r_timeout, exp_last); end
            checks++; if (Errors !== 16'(exp_err) || r_pulses != exp_err) begin errors++; $display("FAIL rand%0d_errors: got %0d pulses=%0d expected %0d", it, Errors, r_pulses, exp_err); end
            checks++; if (r_cycles != 2*(exp_last+1) + r_pause_cnt) begin errors++; $display("FAIL rand%0d_cycles: got %0d expected %0d", it, r_cycles, 2*(exp_last+1) + r_pause_cnt); end
            checks++; if (Pass !== (exp_err == 0)) begin errors++; $display("FAIL rand%0d_pass: got %b expected %b", it, Pass, exp_err == 0); end
            bad_stim = 0;
            for (int k = 0; k < DEPTH; k++) begin
                if (k <= exp_last && (!r_seen[k] || r_stim[k] !== m_stim[k])) bad_stim++;
                if (k > exp_last && r_seen[k]) bad_stim++;
            end
            checks++; if (bad_stim != 0 || r_unstable != 0) begin errors++; $display("FAIL rand%0d_stim: got bad=%0d unstable=%0d expected 0/0", it, bad_stim, r_unstable); end
        end
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; Pause = 1'b0; Load_En = 1'b0;
        Load_Addr = '0; Load_Data = '0; Observed = '0;
        test_reset();
        test_clean_run();
        test_masked();
        test_multi_mismatch();
        test_load_start();
        test_pause();
        test_reset_midrun();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
